// File: rtl/gate_share_arb.sv
// gate_share_arb: round-robin arbiter that time-shares one external 1-bit
// inverter among four requesters, pushing each granted operand through it
// bit-serially (LSB first) and returning the inverted word with a one-cycle ack.
module gate_share_arb #(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     req,
    input  logic [4*W-1:0] a_in,
    output logic [3:0]     ack,
    output logic [W-1:0]   dout,
    output logic [1:0]     gnt_id,
    output logic           busy,
    output logic           gate_a,
    input  logic           gate_y,
    output logic           err
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e          state_q, state_d;
    logic [1:0]      rr_ptr_q, rr_ptr_d;
    logic [1:0]      gnt_id_q, gnt_id_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    opnd_q, opnd_d;
    logic [W-1:0]    res_q, res_d;
    logic [W-1:0]    dout_q, dout_d;
    logic            err_q, err_d;

    logic            win_found;
    logic [1:0]      win_id;
    logic [1:0]      scan_idx;

    // Round-robin scan: first requesting index at or above rr_ptr, wrapping mod 4.
    always_comb begin
        win_found = 1'b0;
        win_id    = rr_ptr_q;
        scan_idx  = 2'd0;
        for (int k = 0; k < 4; k++) begin
            scan_idx = rr_ptr_q + 2'(k);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_id    = scan_idx;
            end
        end
    end

    // Outputs decoded from current state; gate_a is forced low outside SHIFT.
    always_comb begin
        gate_a = (state_q == StShift) ? opnd_q[cnt_q] : 1'b0;
        ack    = (state_q == StDone) ? (4'b0001 << gnt_id_q) : 4'b0000;
        busy   = (state_q != StIdle);
        dout   = dout_q;
        gnt_id = gnt_id_q;
        err    = err_q;
    end

    // Next-state logic: grant, serial shift through the shared gate, completion.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_id_d = gnt_id_q;
        cnt_d    = cnt_q;
        opnd_d   = opnd_q;
        res_d    = res_q;
        dout_d   = dout_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    gnt_id_d = win_id;
                    opnd_d   = a_in[int'(win_id)*W +: W];
                    cnt_d    = '0;
                    state_d  = StShift;
                end
            end
            StShift: begin
                res_d[cnt_q] = gate_y;
                cnt_d        = cnt_q + CW'(1);
                // An inverter must never echo its input.
                if (gate_y == gate_a) begin
                    err_d = 1'b1;
                end
                if (cnt_q == CW'(W - 1)) begin
                    // Capture the completed word so dout is valid in DONE and held after.
                    dout_d  = res_d;
                    state_d = StDone;
                end
            end
            StDone: begin
                rr_ptr_d = gnt_id_q + 2'd1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= 2'd0;
            gnt_id_q <= 2'd0;
            cnt_q    <= '0;
            opnd_q   <= '0;
            res_q    <= '0;
            dout_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_id_q <= gnt_id_d;
            cnt_q    <= cnt_d;
            opnd_q   <= opnd_d;
            res_q    <= res_d;
            dout_q   <= dout_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_gate_share_arb.sv
// tb_gate_share_arb: directed self-checking bench for gate_share_arb (W=8).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_gate_share_arb;

    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [3:0]     req = 4'b0000;
    logic [4*W-1:0] a_in = '0;
    logic [3:0]     ack;
    logic [W-1:0]   dout;
    logic [1:0]     gnt_id;
    logic           busy;
    logic           gate_a;
    logic           gate_y;
    logic           err;
    logic           fault = 1'b0;

    int checks = 0;
    int failures = 0;

    // Shared inverter model; fault turns it into a buffer.
    assign gate_y = fault ? gate_a : ~gate_a;

    always #5 clk = ~clk;

    gate_share_arb #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .a_in   (a_in),
        .ack    (ack),
        .dout   (dout),
        .gnt_id (gnt_id),
        .busy   (busy),
        .gate_a (gate_a),
        .gate_y (gate_y),
        .err    (err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for ack; check latency in rising edges, ack, dout and gnt_id.
    task automatic serve(input string tag, input int id, input logic [7:0] exp_dout,
                         input int exp_lat);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (ack == 4'b0000 && n < 40);
        check_eq({tag, "_lat"}, n, exp_lat);
        check_eq({tag, "_ack"}, {28'b0, ack}, 32'(4'b0001 << id));
        check_eq({tag, "_dout"}, {24'b0, dout}, {24'b0, exp_dout});
        check_eq({tag, "_gnt"}, {30'b0, gnt_id}, id);
        check_eq({tag, "_busy"}, {31'b0, busy}, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_ack", {28'b0, ack}, 0);
        check_eq("rst_dout", {24'b0, dout}, 0);
        check_eq("rst_gnt", {30'b0, gnt_id}, 0);
        check_eq("rst_busy", {31'b0, busy}, 0);
        check_eq("rst_gate_a", {31'b0, gate_a}, 0);
        check_eq("rst_err", {31'b0, err}, 0);
        rst = 1'b0;

        // Single request: 0xA5 -> 0x5A, ack 9 edges after sampling edge
        a_in[0 +: 8] = 8'hA5;
        req = 4'b0001;
        serve("single", 0, 8'h5A, 9);
        check_eq("single_err", {31'b0, err}, 0);
        req = 4'b0000;
        @(negedge clk);
        check_eq("idle_gate_a", {31'b0, gate_a}, 0);
        check_eq("idle_busy", {31'b0, busy}, 0);
        check_eq("hold_dout", {24'b0, dout}, 32'h5A);

        // All four requesting, held: order 0,1,2,3,0 at one grant per W+2 cycles
        do_reset();
        a_in = {8'h96, 8'hF0, 8'h3C, 8'h01};
        req = 4'b1111;
        serve("all0", 0, 8'hFE, 9);
        serve("all1", 1, 8'hC3, 10);
        serve("all2", 2, 8'h0F, 10);
        serve("all3", 3, 8'h69, 10);
        serve("all0b", 0, 8'hFE, 10);
        req = 4'b0000;

        // Fairness: serve 2, then 0101 -> 0 wins (rr_ptr=3), then 2
        do_reset();
        a_in = {8'h00, 8'h81, 8'h00, 8'h42};
        req = 4'b0100;
        serve("fair_a", 2, 8'h7E, 9);
        req = 4'b0101;
        serve("fair_b", 0, 8'hBD, 10);
        req = 4'b0100;
        serve("fair_c", 2, 8'h7E, 10);
        req = 4'b0000;

        // Faulty gate: err sets after first SHIFT cycle and is sticky
        do_reset();
        fault = 1'b1;
        a_in = {8'h00, 8'h00, 8'h33, 8'h5A};
        req = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        check_eq("fault_err_pre", {31'b0, err}, 0);
        @(posedge clk);
        @(negedge clk);
        check_eq("fault_err_set", {31'b0, err}, 1);
        serve("fault_a", 0, 8'h5A, 7);
        req = 4'b0010;
        serve("fault_b", 1, 8'h33, 10);
        check_eq("fault_err_sticky", {31'b0, err}, 1);
        fault = 1'b0;

        // Reset mid-SHIFT: outputs clear immediately, no ack, re-request completes
        a_in[16 +: 8] = 8'h0F;
        req = 4'b0100;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("mid_ack", {28'b0, ack}, 0);
        check_eq("mid_dout", {24'b0, dout}, 0);
        check_eq("mid_gnt", {30'b0, gnt_id}, 0);
        check_eq("mid_busy", {31'b0, busy}, 0);
        check_eq("mid_gate_a", {31'b0, gate_a}, 0);
        check_eq("mid_err", {31'b0, err}, 0);
        @(negedge clk);
        check_eq("mid_hold_ack", {28'b0, ack}, 0);
        rst = 1'b0;
        serve("rereq", 2, 8'hF0, 9);

        // Operand change after grant must not affect the result
        a_in[0 +: 8] = 8'hFF;
        req = 4'b0001;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        a_in[0 +: 8] = 8'h00;
        serve("opchg", 0, 8'h00, 8);
        req = 4'b0000;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
